// File: rtl/connect_four_input_conditioner_pkg.sv
// connect_four_input_conditioner_pkg: shared cycle defaults, counter width and repeat FSM state type
// Defaults assume a 25 MHz clock: 10 ms debounce, 300 ms first repeat, 100 ms repeat interval.
package connect_four_input_conditioner_pkg;
    localparam int DEBOUNCE_CYCLES_DEF = 250000;
    localparam int HOLD_CYCLES_DEF     = 7500000;
    localparam int REPEAT_CYCLES_DEF   = 2500000;
    localparam int CNT_W_DEF           = 23;
    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rep_state_e;
endpackage

// File: rtl/connect_four_input_conditioner_if.sv
// connect_four_input_conditioner_if: raw buttons, enable and conditioned pulses of the input conditioner
// Ports (signals):
//   btn_left_raw / btn_right_raw / btn_drop_raw : raw asynchronous buttons, active-high
//   enable                                       : gates all pulses and repeat timers
//   move_left / move_right / drop_piece          : registered single-cycle pulses
//   btn_state                                    : debounced levels {drop, right, left}
// master drives the buttons and enable; slave is the conditioner.
interface connect_four_input_conditioner_if;
    logic       btn_left_raw;
    logic       btn_right_raw;
    logic       btn_drop_raw;
    logic       enable;
    logic       move_left;
    logic       move_right;
    logic       drop_piece;
    logic [2:0] btn_state;
    modport master (
        output btn_left_raw, btn_right_raw, btn_drop_raw, enable,
        input  move_left, move_right, drop_piece, btn_state
    );
    modport slave (
        input  btn_left_raw, btn_right_raw, btn_drop_raw, enable,
        output move_left, move_right, drop_piece, btn_state
    );
endinterface

// File: rtl/connect_four_input_conditioner_button_debouncer.sv
// connect_four_input_conditioner_button_debouncer: 2-FF synchroniser, debounce counter and press detect
// Ports:
//   clk_25MHz, rst : clock and asynchronous active-high reset
//   raw            : raw asynchronous button
//   level          : debounced level
//   rise           : high for the one cycle after level goes high (press event)
module connect_four_input_conditioner_button_debouncer
    import connect_four_input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic clk_25MHz,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);
    logic [1:0]       sync_q, sync_d;
    logic             level_q, level_d;
    logic             prev_q, prev_d;
    logic             flip;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_25MHz or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
        end
    end

    // sync_q[1] is the synchronised sample; any sample matching the level restarts the count
    always_comb begin
        sync_d  = {sync_q[0], raw};
        flip    = (sync_q[1] != level_q) && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
        cnt_d   = (sync_q[1] == level_q || flip) ? '0 : cnt_q + CNT_W'(1);
        level_d = level_q ^ flip;
        prev_d  = level_q;
    end

    assign level = level_q;
    assign rise  = level_q & ~prev_q;
endmodule

// File: rtl/connect_four_input_conditioner.sv
// connect_four_input_conditioner: debounced Connect Four buttons to single-cycle move/drop pulses
// Ports:
//   clk_25MHz, rst : clock and asynchronous active-high reset
//   io (slave)     : raw buttons and enable in; move_left/move_right/drop_piece pulses and btn_state out
// Left and right auto-repeat while held; drop fires once per press. Drop wins over a move in
// the same cycle, simultaneous left+right cancel each other, and the losers are not deferred.
module connect_four_input_conditioner
    import connect_four_input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF,
    parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input logic                          clk_25MHz,
    input logic                          rst,
    connect_four_input_conditioner_if.slave io
);
    logic [2:0] raw, level, rise;
    logic [1:0] rep_req;
    logic       move_left_q, move_left_d;
    logic       move_right_q, move_right_d;
    logic       drop_piece_q, drop_piece_d;

    assign raw = {io.btn_drop_raw, io.btn_right_raw, io.btn_left_raw};

    for (genvar b = 0; b < 3; b++) begin : g_btn
        connect_four_input_conditioner_button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .clk_25MHz(clk_25MHz),
            .rst      (rst),
            .raw      (raw[b]),
            .level    (level[b]),
            .rise     (rise[b])
        );
    end

    // Repeat FSM per move channel (0 = left, 1 = right). A low debounced level only occurs in
    // HOLD/REPEAT after a fall, so testing the level is the release condition. Holding the FSM
    // in IDLE while disabled means a button held across enable rising needs a fresh press.
    for (genvar m = 0; m < 2; m++) begin : g_rep
        rep_state_e       state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             req;

        always_ff @(posedge clk_25MHz or posedge rst) begin
            if (rst) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        always_comb begin
            state_d = IDLE;
            cnt_d   = '0;
            req     = 1'b0;
            if (io.enable && level[m]) begin
                case (state_q)
                    IDLE: begin
                        req     = rise[m];
                        state_d = rise[m] ? HOLD : IDLE;
                    end
                    HOLD: begin
                        req     = cnt_q == CNT_W'(HOLD_CYCLES - 1);
                        state_d = req ? REPEAT : HOLD;
                        cnt_d   = req ? '0 : cnt_q + CNT_W'(1);
                    end
                    REPEAT: begin
                        req     = cnt_q == CNT_W'(REPEAT_CYCLES - 1);
                        state_d = REPEAT;
                        cnt_d   = req ? '0 : cnt_q + CNT_W'(1);
                    end
                    default: state_d = IDLE;
                endcase
            end
        end

        assign rep_req[m] = req;
    end

    always_comb begin
        drop_piece_d = rise[2] & io.enable;
        move_left_d  = rep_req[0] & ~rep_req[1] & ~drop_piece_d;
        move_right_d = rep_req[1] & ~rep_req[0] & ~drop_piece_d;
    end

    always_ff @(posedge clk_25MHz or posedge rst) begin
        if (rst) begin
            move_left_q  <= 1'b0;
            move_right_q <= 1'b0;
            drop_piece_q <= 1'b0;
        end else begin
            move_left_q  <= move_left_d;
            move_right_q <= move_right_d;
            drop_piece_q <= drop_piece_d;
        end
    end

    assign io.move_left  = move_left_q;
    assign io.move_right = move_right_q;
    assign io.drop_piece = drop_piece_q;
    assign io.btn_state  = level;
endmodule

// File: tb/tb_connect_four_input_conditioner.sv
// tb_connect_four_input_conditioner: directed scenarios plus random buttons against a timing model
module tb_connect_four_input_conditioner;
    localparam int D = 4;
    localparam int H = 20;
    localparam int R = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    connect_four_input_conditioner_if bus();

    connect_four_input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H),
        .REPEAT_CYCLES  (R),
        .CNT_W          (23)
    ) dut (
        .clk_25MHz(clk),
        .rst      (rst),
        .io       (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a level changes once D consecutive synchronised samples disagree with it;
    // each move channel remembers the edge its pulse train started and fires at offsets
    // 0, H, H+R, H+2R, ... while the button stays down and enable stays high.
    logic [2:0]   m_pipe0, m_pipe1, m_level, m_req;
    logic [D-1:0] m_hist [3];
    int           m_press [3];
    int           m_start [2];
    int           cyc = 0;
    int           n;
    logic         m_left, m_right, m_drop;

    task automatic model_step();
        if (rst) begin
            m_pipe0 = '0;
            m_pipe1 = '0;
            m_level = '0;
            m_left  = 1'b0;
            m_right = 1'b0;
            m_drop  = 1'b0;
            for (int c = 0; c < 3; c++) begin
                m_hist[c]  = '0;
                m_press[c] = -1000;
            end
            m_start[0] = -1;
            m_start[1] = -1;
        end else begin
            cyc++;
            for (int c = 0; c < 2; c++) begin
                if (!bus.enable || !m_level[c]) m_start[c] = -1;
                else if (m_start[c] < 0 && cyc == m_press[c] + 1) m_start[c] = cyc;
                n = cyc - m_start[c];
                m_req[c] = m_start[c] >= 0 && (n == 0 || n == H || (n > H && (n - H) % R == 0));
            end
            m_req[2] = bus.enable && cyc == m_press[2] + 1;
            m_drop   = m_req[2];
            m_left   = m_req[0] && !m_req[1] && !m_req[2];
            m_right  = m_req[1] && !m_req[0] && !m_req[2];
            for (int c = 0; c < 3; c++) begin
                m_hist[c] = {m_hist[c][D-2:0], m_pipe1[c]};
                if (m_hist[c] == {D{~m_level[c]}}) begin
                    m_level[c] = ~m_level[c];
                    if (m_level[c]) m_press[c] = cyc;
                end
            end
            m_pipe1 = m_pipe0;
            m_pipe0 = {bus.btn_drop_raw, bus.btn_right_raw, bus.btn_left_raw};
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        check("move_left", int'(bus.move_left), int'(m_left));
        check("move_right", int'(bus.move_right), int'(m_right));
        check("drop_piece", int'(bus.drop_piece), int'(m_drop));
        check("btn_state", int'(bus.btn_state), int'(m_level));
    end

    int pl[$], pr[$], pd[$];
    int hold [3];
    logic [2:0] rv;

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic set_raw(input logic l, input logic r, input logic d);
        bus.btn_left_raw  = l;
        bus.btn_right_raw = r;
        bus.btn_drop_raw  = d;
    endtask

    // Index i = pulse seen in the cycle after the (i+1)-th edge from the call
    task automatic watch(input int k);
        pl.delete();
        pr.delete();
        pd.delete();
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            if (bus.move_left)  pl.push_back(i);
            if (bus.move_right) pr.push_back(i);
            if (bus.drop_piece) pd.push_back(i);
        end
    endtask

    task automatic do_reset(input int k);
        #2 rst = 1'b1;
        #1;
        check("rst_pulses", int'({bus.drop_piece, bus.move_right, bus.move_left}), 0);
        check("rst_state", int'(bus.btn_state), 0);
        tick(k);
        #2 rst = 1'b0;
    endtask

    initial begin
        set_raw(1'b0, 1'b0, 1'b0);
        bus.enable = 1'b1;
        tick(3);
        check("init_state", int'(bus.btn_state), 0);
        #2 rst = 1'b0;
        tick(2);

        // Left held: press latency, then hold and repeat spacing, then release
        set_raw(1'b1, 1'b0, 1'b0);
        watch(43);
        check("s1_count", pl.size(), 4);
        check("s1_first", pl.size() > 0 ? pl[0] : -1, 6);
        check("s1_hold", pl.size() > 1 ? pl[1] : -1, 26);
        check("s1_rep1", pl.size() > 2 ? pl[2] : -1, 34);
        check("s1_rep2", pl.size() > 3 ? pl[3] : -1, 42);
        set_raw(1'b0, 1'b0, 1'b0);
        watch(40);
        check("s1_after_release", pl.size(), 0);
        check("s1_state", int'(bus.btn_state), 0);

        // Bouncing drop, then held: one pulse, no repeat
        set_raw(1'b0, 1'b0, 1'b1);
        tick(2);
        set_raw(1'b0, 1'b0, 1'b0);
        tick(2);
        set_raw(1'b0, 1'b0, 1'b1);
        tick(2);
        set_raw(1'b0, 1'b0, 1'b0);
        tick(2);
        set_raw(1'b0, 1'b0, 1'b1);
        watch(100);
        check("s2_count", pd.size(), 1);
        check("s2_time", pd.size() > 0 ? pd[0] : -1, 6);
        set_raw(1'b0, 1'b0, 1'b0);
        tick(12);

        // Left and right together cancel
        set_raw(1'b1, 1'b1, 1'b0);
        watch(60);
        check("s3_left", pl.size(), 0);
        check("s3_right", pr.size(), 0);
        check("s3_state", int'(bus.btn_state), 3);
        set_raw(1'b0, 1'b0, 1'b0);
        tick(12);

        // Drop collides with a right repeat request
        set_raw(1'b0, 1'b1, 1'b0);
        watch(28);
        check("s4_right_n", pr.size(), 2);
        check("s4_right_hold", pr.size() > 1 ? pr[1] : -1, 26);
        set_raw(1'b0, 1'b1, 1'b1);
        watch(20);
        check("s4_drop", pd.size() > 0 ? pd[0] : -1, 6);
        check("s4_right_next", pr.size() > 0 ? pr[0] : -1, 14);
        check("s4_right_n2", pr.size(), 1);
        set_raw(1'b0, 1'b0, 1'b0);
        tick(12);

        // Disabled press, enable raised while held, re-press
        bus.enable = 1'b0;
        set_raw(1'b1, 1'b0, 1'b0);
        watch(20);
        check("s5_disabled", pl.size(), 0);
        check("s5_state", int'(bus.btn_state[0]), 1);
        bus.enable = 1'b1;
        watch(40);
        check("s5_held_enable", pl.size(), 0);
        set_raw(1'b0, 1'b0, 1'b0);
        tick(12);
        set_raw(1'b1, 1'b0, 1'b0);
        watch(35);
        check("s5_repress", pl.size() > 0 ? pl[0] : -1, 6);
        check("s5_rep", pl.size() > 2 ? pl[2] : -1, 34);

        // Reset in REPEAT while a pulse is high, left still held
        check("s6_pulse_high", int'(bus.move_left), 1);
        do_reset(3);
        watch(10);
        check("s6_count", pl.size(), 1);
        check("s6_first", pl.size() > 0 ? pl[0] : -1, 6);
        set_raw(1'b0, 1'b0, 1'b0);
        tick(12);

        // Random buttons, enable and occasional reset
        rv = '0;
        for (int c = 0; c < 3; c++) hold[c] = 0;
        for (int t = 0; t < 5000; t++) begin
            for (int c = 0; c < 3; c++) begin
                if (hold[c] == 0) begin
                    rv[c]   = 1'($urandom_range(0, 1));
                    hold[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                          : int'($urandom_range(4, 80));
                end else begin
                    hold[c]--;
                end
            end
            set_raw(rv[0], rv[1], rv[2]);
            if (bus.enable ? $urandom_range(0, 299) == 0 : $urandom_range(0, 29) == 0)
                bus.enable = ~bus.enable;
            if ($urandom_range(0, 999) == 0) do_reset(2);
            tick(1);
        end

        bus.enable = 1'b1;
        set_raw(1'b0, 1'b0, 1'b0);
        tick(20);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
